// File: rtl/mram_ctrl_if.sv
`timescale 1ns/1ps
// mram_ctrl_if: request/response bus between a bus master and the MRAM controller.
interface mram_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready;
  logic        rvalid;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, be, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/mram_ctrl.sv
`timescale 1ns/1ps
// mram_ctrl: sequences single accesses to an asynchronous MRAM.
// Every device pin is a flop output, so the strobes cannot glitch.
module mram_ctrl #(
  parameter int unsigned READ_CYCLES  = 4,
  parameter int unsigned WRITE_CYCLES = 2,
  parameter int unsigned TURN_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  mram_ctrl_if.slave  bus,
  output logic [15:0] mram_a,
  output logic        mram_ebar,
  output logic        mram_gbar,
  output logic        mram_wbar,
  output logic        mram_ubbar,
  output logic        mram_lbbar,
  output logic [15:0] mram_dq_out,
  output logic        mram_dq_oe,
  input  logic [15:0] mram_dq_in
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_TURN     = 3'd5
  } state_t;

  localparam logic [7:0] RD_LOAD   = 8'(READ_CYCLES - 1);
  localparam logic [7:0] WR_LOAD   = 8'(WRITE_CYCLES - 1);
  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  be_q;
  logic [15:0] a_q;
  logic        ebar_q;
  logic        gbar_q;
  logic        wbar_q;
  logic        ubbar_q;
  logic        lbbar_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        ready_q;
  logic        rvalid_q;
  logic [15:0] rdata_q;
  logic [15:0] rd_lane_d;

  // Disabled byte lanes read back as zero.
  assign rd_lane_d = {(be_q[1] ? mram_dq_in[15:8] : 8'h00),
                      (be_q[0] ? mram_dq_in[7:0]  : 8'h00)};

  // Access sequencer; outputs are computed for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'h00;
      be_q     <= 2'b00;
      a_q      <= 16'h0000;
      ebar_q   <= 1'b1;
      gbar_q   <= 1'b1;
      wbar_q   <= 1'b1;
      ubbar_q  <= 1'b1;
      lbbar_q  <= 1'b1;
      dq_out_q <= 16'h0000;
      dq_oe_q  <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 16'h0000;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            ready_q <= 1'b0;
            be_q    <= bus.be;
            a_q     <= bus.addr;
            if (bus.we) begin
              dq_out_q <= bus.wdata;
            end
            if (bus.be == 2'b00) begin
              // Nothing to strobe: a read completes at once with zero data.
              state_q <= S_TURN;
              cnt_q   <= TURN_LOAD;
              if (!bus.we) begin
                rvalid_q <= 1'b1;
                rdata_q  <= 16'h0000;
              end
            end else if (bus.we) begin
              state_q <= S_WR_SETUP;
              cnt_q   <= 8'h00;
              ebar_q  <= 1'b0;
              ubbar_q <= ~bus.be[1];
              lbbar_q <= ~bus.be[0];
              dq_oe_q <= 1'b1;
            end else begin
              state_q <= S_RD;
              cnt_q   <= RD_LOAD;
              ebar_q  <= 1'b0;
              gbar_q  <= 1'b0;
              ubbar_q <= ~bus.be[1];
              lbbar_q <= ~bus.be[0];
            end
          end
        end
        S_RD: begin
          if (cnt_q == 8'h00) begin
            rdata_q  <= rd_lane_d;
            rvalid_q <= 1'b1;
            state_q  <= S_TURN;
            cnt_q    <= TURN_LOAD;
            ebar_q   <= 1'b1;
            gbar_q   <= 1'b1;
            ubbar_q  <= 1'b1;
            lbbar_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          cnt_q   <= WR_LOAD;
          wbar_q  <= 1'b0;
        end
        S_WR_PULSE: begin
          if (cnt_q == 8'h00) begin
            state_q <= S_WR_HOLD;
            cnt_q   <= 8'h00;
            wbar_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        S_WR_HOLD: begin
          state_q <= S_TURN;
          cnt_q   <= TURN_LOAD;
          ebar_q  <= 1'b1;
          ubbar_q <= 1'b1;
          lbbar_q <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        S_TURN: begin
          if (cnt_q == 8'h00) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'h00;
          ebar_q  <= 1'b1;
          gbar_q  <= 1'b1;
          wbar_q  <= 1'b1;
          ubbar_q <= 1'b1;
          lbbar_q <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign mram_a      = a_q;
  assign mram_ebar   = ebar_q;
  assign mram_gbar   = gbar_q;
  assign mram_wbar   = wbar_q;
  assign mram_ubbar  = ubbar_q;
  assign mram_lbbar  = lbbar_q;
  assign mram_dq_out = dq_out_q;
  assign mram_dq_oe  = dq_oe_q;

endmodule

// File: doc/mram_ctrl.md
MRAM_CTRL -- requirements
Module: mram_ctrl

Interface
REQ-001 Parameter READ_CYCLES, default 4, clock cycles the device is strobed for a read before data capture; legal range 1-255.
REQ-002 Parameter WRITE_CYCLES, default 2, clock cycles wbar is held low per write; legal range 1-255.
REQ-003 Parameter TURN_CYCLES, default 1, idle cycles with all strobes high after every access; legal range 1-255.
REQ-004 clk  input  1  single clock; all state and outputs update on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  bus request; accepted on a rising edge where req=1 and ready=1.
REQ-007 we  input  1  1 = write, 0 = read; sampled at accept.
REQ-008 addr  input  16  word address; sampled at accept.
REQ-009 wdata  input  16  write data; sampled at accept.
REQ-010 be  input  2  byte enables, bit1 = upper byte, bit0 = lower byte; sampled at accept.
REQ-011 ready  output  1  controller idle and able to accept.
REQ-012 rvalid  output  1  single-cycle pulse qualifying rdata.
REQ-013 rdata  output  16  read data; disabled byte lanes read 0.
REQ-014 mram_a  output  16  device address.
REQ-015 mram_ebar, mram_gbar, mram_wbar, mram_ubbar, mram_lbbar  output  1 each  device strobes, active low.
REQ-016 mram_dq_out  output  16  write data toward the device pad.
REQ-017 mram_dq_oe  output  1  1 = controller drives dq; the pad tristate sits outside this block.
REQ-018 mram_dq_in  input  16  data read back from the device pad.

Function
REQ-019 All device-side outputs SHALL be driven directly from flops, giving glitch-free strobes.
REQ-020 States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN; ready=1 only in IDLE.
REQ-021 Accept (cycle T0) SHALL latch we/addr/wdata/be; mram_a holds the latched address from T1 until the end of the access.
REQ-022 Read: RD for T1..T(READ_CYCLES) with ebar=0, gbar=0, wbar=1, ubbar=~be[1], lbbar=~be[0], dq_oe=0.
REQ-023 Read: on the edge ending the last RD cycle, enabled lanes of mram_dq_in SHALL be captured into rdata; rvalid=1 for exactly the next cycle, which is also the first TURN cycle.
REQ-024 Write: WR_SETUP for 1 cycle with ebar=0, gbar=1, wbar=1, ub/lb per be, dq_oe=1, dq_out=wdata.
REQ-025 Write: WR_PULSE for WRITE_CYCLES cycles with wbar=0 and all other outputs as in WR_SETUP.
REQ-026 Write: WR_HOLD for 1 cycle with wbar=1, while ebar, ub/lb, dq_oe and dq_out remain unchanged.
REQ-027 TURN: all strobes high, dq_oe=0, for TURN_CYCLES cycles, then IDLE.
REQ-028 Timing with defaults: read rvalid in T5 and ready again in T6; write ready again in T6.
REQ-029 gbar=0 and dq_oe=1 SHALL never be asserted in the same cycle; wbar=0 SHALL occur only while ebar=0 and dq_oe=1.
REQ-030 be=00 at accept: no strobe asserted. A read SHALL give rvalid in T1 with rdata=0. Both reads and writes SHALL pass through TURN before returning to IDLE.
REQ-031 req while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-032 Phase counters SHALL be 8 bits and SHALL reload on every state entry.
REQ-033 rdata SHALL hold its value until the next read capture.

Reset
REQ-034 reset_n=0 SHALL immediately, regardless of state, force IDLE, ready=1, rvalid=0, rdata=0, mram_a=0, dq_out=0, dq_oe=0, and all five strobes=1.
REQ-035 Reset asserted mid-access SHALL abort that access with no rvalid, and the first post-reset accept SHALL behave normally.

Verification
REQ-036 Read of addr 0x1234 (defaults, be=11, device model returns 0xBEEF after 35 ns at a 10 ns clock) -> gbar/ebar low for T1-T4, rvalid in T5 with rdata=0xBEEF, ready=1 in T6.
REQ-037 Write of 0xA5C3 to 0x0010 (be=11), then read back 0x0010 -> wbar low for exactly T2-T3, dq_oe=1 for T1-T4, read returns 0xA5C3.
REQ-038 Byte writes: be=01 with 0x00FF then be=10 with 0xAB00 to 0x0020, then full read -> 0xABFF; a read with be=01 returns 0x00FF.
REQ-039 Back-to-back: req held high for 3 writes -> one access per 6 cycles, no missed or duplicated wbar pulse, and no cycle with gbar=0 and dq_oe=1.
REQ-040 reset_n pulsed low during WR_PULSE -> wbar=1 and dq_oe=0 the same instant, no rvalid, and the next read completes correctly.
REQ-041 Read with be=00 -> no strobe activity, rvalid in T1 with rdata=0; READ_CYCLES=1, WRITE_CYCLES=1, TURN_CYCLES=3 instance -> read rvalid in T2 and ready in T5.
